// File: rtl/dram_reader.sv
// dram_reader: walks an async-read RAM from base with a wrapping stride and streams words out
`timescale 1ns/1ps
module dram_reader #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 4096,
    parameter int RAM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base,
    input  logic [RAM_ADDR_WIDTH-1:0] stride,
    input  logic [RAM_ADDR_WIDTH:0]   len,
    output logic [RAM_ADDR_WIDTH-1:0] raddr,
    input  logic [RAM_WIDTH-1:0]      rdata,
    output logic [RAM_WIDTH-1:0]      m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);
    localparam int AW = RAM_ADDR_WIDTH;
    localparam logic [AW:0] DEPTH = (AW+1)'(RAM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] ptr, stride_r;
    logic [AW:0]   remaining, sum, nxt;
    logic          accept, fetch, finish;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state: empty commands never leave IDLE; DRAIN waits for the last handshake
    always_comb begin
        state_nx = state == IDLE  ? ((accept && len != '0) ? RUN : IDLE) :
                   state == RUN   ? ((fetch && remaining == 1) ? DRAIN : RUN) :
                   state == DRAIN ? (finish ? IDLE : DRAIN) : IDLE;
    end

    // control strobes and the wrapped next pointer
    always_comb begin
        accept = state == IDLE && start;
        fetch  = state == RUN && (!m_valid || m_ready) && remaining != '0;
        finish = state == DRAIN && m_ready;
        busy   = state != IDLE;
        raddr  = ptr;
        sum    = {1'b0, ptr} + {1'b0, stride_r};
        nxt    = sum >= DEPTH ? sum - DEPTH : sum;
    end

    // datapath: command latch, fetch into the output register, hold while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr       <= '0;
            stride_r  <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (accept && len == '0) || finish;
            if (accept) begin
                ptr       <= base;
                stride_r  <= stride;
                remaining <= len;
            end
            if (fetch) begin
                m_data    <= rdata;
                m_valid   <= 1'b1;
                m_last    <= remaining == 1;
                remaining <= remaining - 1'b1;
                ptr       <= nxt[AW-1:0];
            end
            if (finish) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dram_reader.sv
// tb_dram_reader: table-driven and randomized checks of dram_reader against a queue model
`timescale 1ns/1ps
module tb_dram_reader;
    localparam int W  = 32;
    localparam int D  = 4096;
    localparam int AW = 12;

    logic          clk = 0, rstn = 0, start = 0, m_ready = 0;
    logic [AW-1:0] base = '0, stride = '0, raddr;
    logic [AW:0]   len = '0;
    logic [W-1:0]  rdata, m_data;
    logic          m_valid, m_last, busy, done;
    logic [W-1:0]  mem [D];

    typedef struct {logic [W-1:0] data; logic last;} beat_t;
    typedef struct {int base; int stride; int len; int mode; int exp_first; int exp_done; int exp_busy;} cmd_t;

    beat_t        exp_q[$];
    beat_t        e;
    int           checks = 0, failures = 0, beats = 0;
    bit           sb_en = 1, prev_stall = 0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always #5 clk = ~clk;
    assign rdata = mem[raddr];

    dram_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .stride(stride), .len(len),
        .raddr(raddr), .rdata(rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int mode, input int n);
        logic pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        if (mode == 1) return $urandom_range(0, 3) != 0;
        if (mode == 2 && n < 7) return pat[n];
        return 1'b1;
    endfunction

    // scoreboard and stream-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rstn) prev_stall = 0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_valid", m_valid, 0);
            end
            if (sb_en && m_valid && m_ready) begin
                beats++;
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", m_last, e.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic run_cmd(input int b, input int s, input int l, input int mode, input int stray,
                           input bit now, output int first_v, output int done_n, output int busy_n);
        int n;
        if (!now) begin @(posedge clk); #1; end
        base = b; stride = s; len = l; start = 1; beats = 0;
        for (int k = 0; k < l; k++) exp_q.push_back(beat_t'{mem[(b + k * s) % D], k == l - 1});
        @(posedge clk); #1;
        start = 0; m_ready = rdy(mode, 0);
        n = 0; first_v = 0; busy_n = 0; done_n = 0;
        while (done_n == 0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (m_valid && first_v == 0) first_v = n;
            if (busy) busy_n++;
            if (done) done_n = n;
            else begin
                @(posedge clk); #1;
                m_ready = rdy(mode, n);
                if (n == stray) begin start = 1; base = 12'h050; len = 2; stride = 1; end
                else start = 0;
            end
        end
        chk("done_seen", done_n != 0, 1);
        chk("beat_count", beats, l);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_raddr", raddr, (b + l * s) % D);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_raddr"}, raddr, 0);
    endtask

    initial begin
        int   fv, dn, bn, n, b, s, l, mode;
        cmd_t tbl [6];
        for (int i = 0; i < D; i++) mem[i] = i + 'h100;
        tbl = '{
            '{4,    1,    4,    0, 2, 6,    5},
            '{4,    1,    4,    2, -1, -1, -1},
            '{4094, 3,    3,    0, 2, 5,    4},
            '{7,    5,    0,    0, 0, 1,    0},
            '{0,    1,    4096, 0, 2, 4098, 4097},
            '{100,  4095, 5,    1, -1, -1, -1}
        };
        #12;
        chk_zero("reset");
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(tbl[i].base, tbl[i].stride, tbl[i].len, tbl[i].mode, 0, 0, fv, dn, bn);
            if (tbl[i].exp_done >= 0) begin
                chk("first_valid", fv, tbl[i].exp_first);
                chk("done_cycle", dn, tbl[i].exp_done);
                chk("busy_cycles", bn, tbl[i].exp_busy);
            end
        end

        run_cmd(200, 7, 8, 0, 3, 0, fv, dn, bn);
        chk("stray_done_cycle", dn, 10);

        run_cmd(300, 1, 3, 0, 0, 0, fv, dn, bn);
        run_cmd(50, 2, 3, 0, 0, 1, fv, dn, bn);
        chk("restart_first_valid", fv, 2);
        chk("restart_done_cycle", dn, 5);

        sb_en = 0;
        @(posedge clk); #1;
        base = 10; stride = 2; len = 8; start = 1; m_ready = 1;
        @(posedge clk); #1;
        start = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(m_valid && m_data == mem[14]) && n < 20);
        chk("pre_reset_beat2", m_data, mem[14]);
        #2 rstn = 0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rstn = 1; sb_en = 1;
        run_cmd(500, 3, 6, 1, 0, 0, fv, dn, bn);

        for (int i = 0; i < D; i++) mem[i] = $urandom;
        for (int i = 0; i < 20; i++) begin
            b = $urandom_range(0, D - 1);
            s = $urandom_range(0, D - 1);
            l = $urandom_range(0, 40);
            mode = $urandom_range(0, 1);
            run_cmd(b, s, l, mode, 0, 0, fv, dn, bn);
            if (mode == 0) chk("rand_done_cycle", dn, l == 0 ? 1 : l + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_reader.md
# dram_reader

Streaming read engine for the distributed weight/activation RAM. On a start command it walks the RAM's asynchronous read port from a base address with a programmable stride. It emits one word per cycle on a valid/ready stream, with a last flag, toward the LSTM datapath (MAC/gate units). It is the consumer-side counterpart of the RAM's write path. It drives `raddr` and samples `dout` combinationally in the same cycle.

## Interface
- `RAM_WIDTH`, 32, data word width; must match the RAM.
- `RAM_DEPTH`, 4096, number of RAM words; need not be a power of two.
- `RAM_ADDR_WIDTH`, 12, address width; 2^RAM_ADDR_WIDTH >= RAM_DEPTH.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  command strobe; accepted only when `busy`=0.
- `base`  in  RAM_ADDR_WIDTH  first read address; sampled on accepted `start`.
- `stride`  in  RAM_ADDR_WIDTH  address increment per word, sampled on accepted `start`; must be < RAM_DEPTH.
- `len`  in  RAM_ADDR_WIDTH+1  word count (0..RAM_DEPTH), sampled on accepted `start`.
- `raddr`  out  RAM_ADDR_WIDTH  to RAM read address.
- `rdata`  in  RAM_WIDTH  from RAM `dout` (combinational).
- `m_data`  out  RAM_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from consumer.
- `m_last`  out  1  marks final word of a command.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse on command completion.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 loads ptr<=base, stride_r<=stride, remaining<=len, and raises `busy`.
  - The next state is RUN if len!=0. If len=0, the next state stays IDLE and `done` pulses for 1 cycle with no stream beats.
- `raddr` = ptr at all times (registered pointer, no combinational path from inputs).
- RUN, fetch condition = (!m_valid || m_ready) && remaining!=0. On fetch:
  - m_data<=rdata, m_valid<=1, m_last<=(remaining==1).
  - remaining<=remaining-1.
  - ptr<=next(ptr).
- next(ptr): sum = ptr+stride_r computed in RAM_ADDR_WIDTH+1 bits; if sum >= RAM_DEPTH, subtract RAM_DEPTH. This gives wrap modulo RAM_DEPTH.
- RUN→DRAIN on the fetch that loads the last word (remaining==1).
- DRAIN: hold m_data/m_last until m_ready. On handshake: m_valid<=0, m_last<=0, `busy`<=0, `done`<=1 for one cycle, →IDLE.
- m_valid=1 && m_ready=0: m_data, m_last, and ptr are frozen (AXI-stream stability). No data loss or duplication.
- `start` while `busy`=1 is ignored entirely; latched parameters are unchanged.
- `done` and an accepted new `start` may occur in the same cycle only if `busy`=0. `start` is therefore ignored in the `done` cycle's preceding DRAIN state, and accepted from the `done` cycle onward.
- Reset (async, any state) returns:
  - state=IDLE, ptr=0, remaining=0.
  - m_valid=0, m_last=0, m_data=0, busy=0, done=0, raddr=0.
  - An in-flight stream is discarded without `m_last`.

## Timing
- Start accepted at edge E0. Word 0 is fetched at E1, and m_valid=1 in the cycle after E1. Start-to-first-valid latency = 2 cycles from the `start` cycle.
- Throughput is 1 word/cycle with m_ready held high. A len=N command completes N+1 cycles after entering RUN.
- `busy` rises the cycle after accepted `start`. It falls in the same cycle `done` is high.
- `done` is high for exactly 1 cycle: after the last-beat handshake, or the cycle after a len=0 start.
- The RAM read is combinational. The RAM must not be written at ptr in the fetch cycle if old data is required; that ordering is the scheduler's responsibility.

## Test plan
- Basic: RAM[i]=i+0x100; start base=4, stride=1, len=4, m_ready=1 → beats 0x104..0x107 on consecutive cycles, m_last only on 0x107, `done` 1 cycle later, busy 5 cycles.
- Backpressure: same command, m_ready toggling 1,0,0,1,0,1,1 → exactly 4 beats in order, m_data/m_last stable while stalled, no duplicates.
- Wrap/stride: RAM_DEPTH=4096, base=4094, stride=3, len=3 → addresses 4094, 1, 4, with m_last on address 4.
- len=0 and full-depth: len=0 → no m_valid, `done` pulse the cycle after `start`; len=4096, stride=1 → 4096 beats covering every address once, wrapping to base.
- Busy start: second `start` (base=0x50) mid-command → ignored, original stream unchanged; `start` in the `done` cycle → accepted, first beat 2 cycles later.
- Reset mid-operation: assert rstn=0 during beat 2 of len=8 → all outputs 0 immediately (async). After release, a new command runs cleanly from its own base.
